// File: rtl/sdrc_resp_pkg.sv
// Shared types and constants for the SDRC-compatible BRAM responder.
package sdrc_resp_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ,
        ST_REFRESH,
        ST_SLEEP
    } state_e;

    localparam int unsigned REFRESH_INTERVAL = 1024;
    localparam int unsigned REFRESH_CYCLES   = 8;
    localparam int unsigned REFRESH_CNT_W    = $clog2(REFRESH_INTERVAL);

endpackage

// File: rtl/sdrc_resp_mem.sv
// Simple dual-port 32-bit RAM with byte enables and a registered read port.
module sdrc_resp_mem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem_q [0:DEPTH-1];
    logic [31:0] rdata_q;

    // No reset here so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdrc_bram_responder.sv
// Block-RAM model answering the SDRAM-controller user interface with bursts.
// Optional periodic refresh stalls are enabled with SDRC_RESP_REFRESH_EN.
module sdrc_bram_responder
    import sdrc_resp_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int INIT_CYCLES  = 16,
    parameter int READ_LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        I_sdrc_wr_n,
    input  logic        I_sdrc_rd_n,
    input  logic [20:0] I_sdrc_addr,
    input  logic [6:0]  I_sdrc_data_len,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic        I_sdrc_selfrefresh,
    input  logic        I_sdrc_power_down,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_busy_n,
    output logic        O_sdrc_rd_valid,
    output logic        O_sdrc_wrd_ack
);

    state_e                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [6:0]              len_q, len_d;
    logic                    initDone_q, initDone_d;
    logic                    memWe;
    logic [31:0]             memRdata;
    logic                    lowPowerReq;
    logic                    unusedAddrBits;

    assign lowPowerReq    = I_sdrc_selfrefresh | I_sdrc_power_down;
    assign unusedAddrBits = ^I_sdrc_addr[20:ADDR_WIDTH];

`ifdef SDRC_RESP_REFRESH_EN
    logic [REFRESH_CNT_W-1:0] refCnt_q;
    logic                     refReq_q;
    logic                     refTake;

    // A request is raised each time the free-running counter wraps and is
    // held until the FSM finds an IDLE cycle without a command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            refCnt_q <= '0;
            refReq_q <= 1'b0;
        end else begin
            refCnt_q <= refCnt_q + REFRESH_CNT_W'(1);
            if (refTake) begin
                refReq_q <= 1'b0;
            end else if (refCnt_q == REFRESH_CNT_W'(REFRESH_INTERVAL - 1)) begin
                refReq_q <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            initDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            initDone_q <= initDone_d;
        end
    end

    // The read pointer is issued one cycle ahead of READ because the RAM
    // output is registered; addr_q always drives both RAM ports.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        len_d      = len_q;
        initDone_d = initDone_q;
        memWe      = 1'b0;
`ifdef SDRC_RESP_REFRESH_EN
        refTake    = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                if (cnt_q == 16'(INIT_CYCLES - 1)) begin
                    cnt_d      = '0;
                    initDone_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (!I_sdrc_wr_n) begin
                    addr_d  = I_sdrc_addr[ADDR_WIDTH-1:0];
                    len_d   = I_sdrc_data_len;
                    state_d = ST_WRITE;
                end else if (!I_sdrc_rd_n) begin
                    addr_d  = I_sdrc_addr[ADDR_WIDTH-1:0];
                    len_d   = I_sdrc_data_len;
                    state_d = ST_READ_WAIT;
                end
`ifdef SDRC_RESP_REFRESH_EN
                else if (refReq_q) begin
                    refTake = 1'b1;
                    state_d = ST_REFRESH;
                end
`endif
                else if (lowPowerReq) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_WRITE: begin
                memWe  = 1'b1;
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (cnt_q == {9'd0, len_q}) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_READ_WAIT: begin
                if (cnt_q == 16'(READ_LATENCY - 2)) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = '0;
                    state_d = ST_READ;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_READ: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (cnt_q == {9'd0, len_q}) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_REFRESH: begin
`ifdef SDRC_RESP_REFRESH_EN
                if (cnt_q == 16'(REFRESH_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_SLEEP: begin
                if (!lowPowerReq) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    sdrc_resp_mem #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (memWe),
        .be_i    (~I_sdrc_dqm),
        .waddr_i (addr_q),
        .wdata_i (I_sdrc_data),
        .raddr_i (addr_q),
        .rdata_o (memRdata)
    );

    assign O_sdrc_init_done = initDone_q;
    assign O_sdrc_busy_n    = (state_q == ST_IDLE);
    assign O_sdrc_rd_valid  = (state_q == ST_READ);
    assign O_sdrc_wrd_ack   = (state_q == ST_WRITE);
    assign O_sdrc_data      = O_sdrc_rd_valid ? memRdata : 32'd0;

endmodule

// File: tb/tb_sdrc_bram_responder.sv
// Scoreboard bench for sdrc_bram_responder: stimulus queues expected beats,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sdrc_bram_responder;

    localparam int RL = 4;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rdExp_t;

    logic        clock;
    logic        reset_n;
    logic        I_sdrc_wr_n;
    logic        I_sdrc_rd_n;
    logic [20:0] I_sdrc_addr;
    logic [6:0]  I_sdrc_data_len;
    logic [3:0]  I_sdrc_dqm;
    logic [31:0] I_sdrc_data;
    logic        I_sdrc_selfrefresh;
    logic        I_sdrc_power_down;
    logic [31:0] O_sdrc_data;
    logic        O_sdrc_init_done;
    logic        O_sdrc_busy_n;
    logic        O_sdrc_rd_valid;
    logic        O_sdrc_wrd_ack;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lastAccept = 0;
    rdExp_t      rdQ[$];
    int          ackQ[$];
    logic [31:0] wVec [8];
    logic [3:0]  wMsk [8];
    logic [31:0] rVec [8];

    sdrc_bram_responder dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .I_sdrc_wr_n        (I_sdrc_wr_n),
        .I_sdrc_rd_n        (I_sdrc_rd_n),
        .I_sdrc_addr        (I_sdrc_addr),
        .I_sdrc_data_len    (I_sdrc_data_len),
        .I_sdrc_dqm         (I_sdrc_dqm),
        .I_sdrc_data        (I_sdrc_data),
        .I_sdrc_selfrefresh (I_sdrc_selfrefresh),
        .I_sdrc_power_down  (I_sdrc_power_down),
        .O_sdrc_data        (O_sdrc_data),
        .O_sdrc_init_done   (O_sdrc_init_done),
        .O_sdrc_busy_n      (O_sdrc_busy_n),
        .O_sdrc_rd_valid    (O_sdrc_rd_valid),
        .O_sdrc_wrd_ack     (O_sdrc_wrd_ack)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every beat the DUT presents must match the head of its queue,
    // both in value and in the cycle it appears.
    always @(negedge clock) begin
        if (reset_n) begin
            if (O_sdrc_rd_valid) begin
                if (rdQ.size() == 0) begin
                    checkOutput("unexpected rd_valid", 32'(O_sdrc_rd_valid), 32'd0);
                end else begin
                    rdExp_t e;
                    e = rdQ.pop_front();
                    checkOutput("read data", O_sdrc_data, e.data);
                    checkOutput("read beat cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                checkOutput("data zero when not valid", O_sdrc_data, 32'd0);
            end
            if (O_sdrc_wrd_ack) begin
                if (ackQ.size() == 0) begin
                    checkOutput("unexpected wrd_ack", 32'(O_sdrc_wrd_ack), 32'd0);
                end else begin
                    int c;
                    c = ackQ.pop_front();
                    checkOutput("wrd_ack cycle", 32'(cyc), 32'(c));
                end
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (O_sdrc_busy_n !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checkOutput("busy_n ready for command", 32'(O_sdrc_busy_n), 32'd1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((rdQ.size() != 0 || ackQ.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        checkOutput("burst drained", 32'(rdQ.size() + ackQ.size()), 32'd0);
        @(negedge clock);
    endtask

    // Write burst using wVec/wMsk; optionally also drives rd_n low (held until
    // the last ack) and/or raises selfrefresh together with the command.
    task automatic applyStimulus_write(input logic [20:0] addr, input int len,
                                       input logic bothLow, input logic lp);
        int a;
        waitIdle();
        I_sdrc_wr_n        = 1'b0;
        I_sdrc_rd_n        = bothLow ? 1'b0 : 1'b1;
        I_sdrc_selfrefresh = lp;
        I_sdrc_addr        = addr;
        I_sdrc_data_len    = 7'(len);
        I_sdrc_data        = wVec[0];
        I_sdrc_dqm         = wMsk[0];
        a = cyc;
        lastAccept = a;
        for (int i = 0; i <= len; i++) ackQ.push_back(a + 1 + i);
        @(negedge clock);
        I_sdrc_wr_n = 1'b1;
        for (int i = 1; i <= len; i++) begin
            @(negedge clock);
            I_sdrc_data = wVec[i];
            I_sdrc_dqm  = wMsk[i];
        end
        I_sdrc_rd_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic applyStimulus_read(input logic [20:0] addr, input int len);
        int a;
        rdExp_t e;
        waitIdle();
        I_sdrc_rd_n     = 1'b0;
        I_sdrc_addr     = addr;
        I_sdrc_data_len = 7'(len);
        a = cyc;
        lastAccept = a;
        for (int i = 0; i <= len; i++) begin
            e.data = rVec[i];
            e.cyc  = a + RL + i;
            rdQ.push_back(e);
        end
        @(negedge clock);
        I_sdrc_rd_n = 1'b1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("reset init_done", 32'(O_sdrc_init_done), 32'd0);
        checkOutput("reset busy_n", 32'(O_sdrc_busy_n), 32'd0);
        checkOutput("reset rd_valid", 32'(O_sdrc_rd_valid), 32'd0);
        checkOutput("reset wrd_ack", 32'(O_sdrc_wrd_ack), 32'd0);
        checkOutput("reset data", O_sdrc_data, 32'd0);
    endtask

    task automatic releaseAndInit();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (15) @(negedge clock);
        checkOutput("init_done after 15 cycles", 32'(O_sdrc_init_done), 32'd0);
        checkOutput("busy_n after 15 cycles", 32'(O_sdrc_busy_n), 32'd0);
        @(negedge clock);
        checkOutput("init_done after 16 cycles", 32'(O_sdrc_init_done), 32'd1);
        checkOutput("busy_n after 16 cycles", 32'(O_sdrc_busy_n), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual running, required finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n            = 1'b0;
        I_sdrc_wr_n        = 1'b1;
        I_sdrc_rd_n        = 1'b1;
        I_sdrc_addr        = '0;
        I_sdrc_data_len    = '0;
        I_sdrc_dqm         = '0;
        I_sdrc_data        = '0;
        I_sdrc_selfrefresh = 1'b0;
        I_sdrc_power_down  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wVec[i] = '0;
            wMsk[i] = '0;
            rVec[i] = '0;
        end

        @(negedge clock);
        #1 checkResetOutputs();
        releaseAndInit();

        // 4-beat write at 0x010, immediately read back
        wVec[0] = 32'h11111111; wVec[1] = 32'h22222222;
        wVec[2] = 32'h33333333; wVec[3] = 32'h44444444;
        applyStimulus_write(21'h010, 3, 1'b0, 1'b0);
        rVec[0] = 32'h11111111; rVec[1] = 32'h22222222;
        rVec[2] = 32'h33333333; rVec[3] = 32'h44444444;
        applyStimulus_read(21'h010, 3);
        waitDrain();

        // byte mask: clear word, then write 0xAABBCCDD with dqm 0x5
        wVec[0] = 32'h00000000; wMsk[0] = 4'h0;
        applyStimulus_write(21'h020, 0, 1'b0, 1'b0);
        wVec[0] = 32'hAABBCCDD; wMsk[0] = 4'h5;
        applyStimulus_write(21'h020, 0, 1'b0, 1'b0);
        wMsk[0] = 4'h0;
        rVec[0] = 32'hAA00CC00;
        applyStimulus_read(21'h020, 0);
        waitDrain();

        // address wrap at top of memory
        wVec[0] = 32'hA0A0A0A0; wVec[1] = 32'hA1A1A1A1;
        wVec[2] = 32'hA2A2A2A2; wVec[3] = 32'hA3A3A3A3;
        applyStimulus_write(21'h3FE, 3, 1'b0, 1'b0);
        rVec[0] = 32'hA0A0A0A0; rVec[1] = 32'hA1A1A1A1;
        rVec[2] = 32'hA2A2A2A2; rVec[3] = 32'hA3A3A3A3;
        applyStimulus_read(21'h3FE, 3);
        waitDrain();
        rVec[0] = 32'hA2A2A2A2; rVec[1] = 32'hA3A3A3A3;
        applyStimulus_read(21'h1FFC00, 1);
        waitDrain();

        // simultaneous wr_n/rd_n, rd_n held low through the burst
        wVec[0] = 32'h55550001; wVec[1] = 32'h55550002;
        applyStimulus_write(21'h030, 1, 1'b1, 1'b0);
        waitDrain();
        repeat (8) @(negedge clock);
        rVec[0] = 32'h55550001; rVec[1] = 32'h55550002;
        applyStimulus_read(21'h030, 1);
        waitDrain();

        // sleep entry/exit and retention
        waitIdle();
        I_sdrc_power_down = 1'b1;
        @(negedge clock);
        checkOutput("busy_n in sleep", 32'(O_sdrc_busy_n), 32'd0);
        repeat (3) @(negedge clock);
        I_sdrc_power_down  = 1'b0;
        I_sdrc_selfrefresh = 1'b1;
        @(negedge clock);
        checkOutput("busy_n sleep via selfrefresh", 32'(O_sdrc_busy_n), 32'd0);
        I_sdrc_selfrefresh = 1'b0;
        checkOutput("busy_n same cycle as wake", 32'(O_sdrc_busy_n), 32'd0);
        @(negedge clock);
        checkOutput("busy_n after wake", 32'(O_sdrc_busy_n), 32'd1);
        rVec[0] = 32'h11111111; rVec[1] = 32'h22222222;
        applyStimulus_read(21'h010, 1);
        waitDrain();

        // low-power request during a burst: burst completes, then sleep
        wVec[0] = 32'h77770000; wVec[1] = 32'h77770001; wVec[2] = 32'h77770002;
        applyStimulus_write(21'h040, 2, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("busy_n sleep after burst", 32'(O_sdrc_busy_n), 32'd0);
        checkOutput("acks complete before sleep", 32'(ackQ.size()), 32'd0);
        I_sdrc_selfrefresh = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rVec[0] = 32'h77770000; rVec[1] = 32'h77770001; rVec[2] = 32'h77770002;
        applyStimulus_read(21'h040, 2);
        waitDrain();

        // reset asserted during the second read beat
        rVec[0] = 32'h11111111; rVec[1] = 32'h22222222;
        rVec[2] = 32'h33333333; rVec[3] = 32'h44444444;
        applyStimulus_read(21'h010, 3);
        while (cyc < lastAccept + RL + 1) @(negedge clock);
        checkOutput("second beat valid", 32'(O_sdrc_rd_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1 checkResetOutputs();
        rdQ.delete();
        releaseAndInit();

        wVec[0] = 32'hCAFEF00D;
        applyStimulus_write(21'h005, 0, 1'b0, 1'b0);
        rVec[0] = 32'hCAFEF00D;
        applyStimulus_read(21'h005, 0);
        waitDrain();

`ifdef SDRC_RESP_REFRESH_EN
        begin
            int n = 0;
            int low = 0;
            while (O_sdrc_busy_n === 1'b1 && n < 1200) begin
                @(negedge clock);
                n++;
            end
            while (O_sdrc_busy_n === 1'b0 && low < 20) begin
                @(negedge clock);
                low++;
            end
            checkOutput("refresh busy_n low cycles", 32'(low), 32'd8);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
